// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, word helpers
// and the decryption FSM state type.
package aes_pkg;

  localparam int NR = 10;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST = 8'h36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPAND,
    S_INIT,
    S_ROUND,
    S_FINAL
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    return a[0] ? ((a >> 1) ^ 8'h8d) : (a >> 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b,
                                       input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3)
             ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; bypass_mix_i drops
// InvMixColumns for the final round.
import aes_pkg::*;

module aes_inv_round (
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         bypass_mix_i,
  output logic [127:0] st_o
);

  // Byte n of the block sits at bits [127-8n -: 8], column-major.
  function automatic logic [127:0] inv_shift_sub(
      input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*((c + r) % 4)) -: 8] =
          inv_sbox(s[127 - 8*(r + 4*c) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                         ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                         ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                         ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                         ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [127:0] sub_add;

  assign sub_add = inv_shift_sub(st_i) ^ rk_i;
  assign st_o = bypass_mix_i ? sub_add : inv_mix(sub_add);

endmodule

// File: rtl/aes_128_inv_iter.sv
// Iterative AES-128 decryptor: forward key expansion to k10, then
// ten inverse rounds walking the key schedule backwards.
import aes_pkg::*;

module aes_128_inv_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] in,
  output logic         busy,
  output logic         done,
  output logic [127:0] out
);

  localparam logic [3:0] CNT_LAST = 4'(NR - 1);

  function automatic logic [127:0] fwd_key_step(
      input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_key_step(
      input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] out_q, out_d;
  logic [127:0] round_o;

  aes_inv_round u_round (
    .st_i         (st_q),
    .rk_i         (rk_q),
    .bypass_mix_i (state_q == S_FINAL),
    .st_o         (round_o)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: expand, whiten, nine full rounds, final round
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_EXPAND;
      S_EXPAND: if (cnt_q == CNT_LAST) state_d = S_INIT;
      S_INIT:   state_d = S_ROUND;
      S_ROUND:  if (cnt_q == 4'd1) state_d = S_FINAL;
      S_FINAL:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: datapath next values per state
  always_comb begin
    st_d   = st_q;
    rk_d   = rk_q;
    rcon_d = rcon_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    out_d  = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          st_d   = in;
          rk_d   = key;
          rcon_d = RCON_FIRST;
          cnt_d  = 4'd0;
          busy_d = 1'b1;
        end
      end
      S_EXPAND: begin
        rk_d   = fwd_key_step(rk_q, rcon_q);
        rcon_d = xtime(rcon_q);
        cnt_d  = cnt_q + 4'd1;
      end
      S_INIT: begin
        st_d   = st_q ^ rk_q;
        rk_d   = inv_key_step(rk_q, RCON_LAST);
        rcon_d = 8'h1b;
        cnt_d  = CNT_LAST;
      end
      S_ROUND: begin
        st_d   = round_o;
        rk_d   = inv_key_step(rk_q, rcon_q);
        rcon_d = inv_xtime(rcon_q);
        cnt_d  = cnt_q - 4'd1;
      end
      S_FINAL: begin
        out_d  = round_o;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '0;
      rk_q   <= '0;
      rcon_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      st_q   <= st_d;
      rk_q   <= rk_d;
      rcon_q <= rcon_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      out_q  <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_aes_128_inv_iter.sv
// Bench for aes_128_inv_iter: textbook AES model, FIPS vectors,
// back-to-back, busy-time noise, async reset and random loopback.
module tb_aes_128_inv_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] din;
  logic         busy;
  logic         done;
  logic [127:0] dout;

  always #5 clk = ~clk;

  aes_128_inv_iter #(.NR(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .in    (din),
    .busy  (busy),
    .done  (done),
    .out   (dout)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] pt;
    int           c0;
  } exp_t;

  exp_t q[$];
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  task automatic init_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
             ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] k,
                                             input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    return {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] x,
                                         input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = inv ? isb[x[127 - 8*i -: 8]]
                              : sb[x[127 - 8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] x,
                                           input bit inv);
    logic [127:0] o;
    int a, b;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        a = r + 4*c;
        b = r + 4*((c + r) % 4);
        if (inv) o[127 - 8*b -: 8] = x[127 - 8*a -: 8];
        else     o[127 - 8*a -: 8] = x[127 - 8*b -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] x,
                                         input bit inv);
    logic [7:0] m [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    logic [127:0] o;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = x[127 - 8*(4*c + j) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) acc ^= gm(m[(j - r + 4) % 4], a[j]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] k,
                                           input logic [127:0] p);
    logic [127:0] s;
    s = p ^ round_key(k, 0);
    for (int r = 1; r <= 10; r++) begin
      s = shift_r(sub_b(s, 0), 0);
      if (r < 10) s = mix_c(s, 0);
      s ^= round_key(k, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] decrypt(input logic [127:0] k,
                                           input logic [127:0] c);
    logic [127:0] s;
    s = c ^ round_key(k, 10);
    for (int r = 9; r >= 0; r--) begin
      s = sub_b(shift_r(s, 1), 1) ^ round_key(k, r);
      if (r > 0) s = mix_c(s, 1);
    end
    return s;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: every cycle out reported or held, busy, done shape
  logic [127:0] last_out = '0;
  logic         prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_out = '0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_single", 128'(prev_done), 128'd0);
        if (q.size() == 0) begin
          chk("done_unexpected", 128'd1, 128'd0);
        end else begin
          e = q.pop_front();
          chk("out", dout, e.pt);
          chk("latency", 128'(cyc - e.c0), 128'd21);
        end
        last_out = dout;
      end else begin
        chk("out_hold", dout, last_out);
      end
      chk("busy", 128'(busy), 128'(q.size() != 0));
      prev_done = done;
    end
  end

  task automatic start_op(input logic [127:0] k, input logic [127:0] c,
                          input logic [127:0] p);
    exp_t e;
    key = k;
    din = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.pt = p;
    e.c0 = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    chk("done_timeout", 128'(ok), 128'd1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d1;
    logic [127:0] k;
    logic [127:0] p;
    rst = 1'b1;
    start = 1'b0;
    key = '0;
    din = '0;
    init_tables();
    #12;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_out", dout, 128'd0);
    chk("model_enc_c1", encrypt(K1, P1), C1);
    chk("model_dec_b", decrypt(KB, CB), PB);
    chk("model_sbox", 128'(sb[8'h53]), 128'hed);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    start_op(K1, C1, P1);
    wait_done();
    chk("c1_out", dout, P1);
    d1 = cyc;
    start_op(KB, CB, PB);
    wait_done();
    chk("b_out", dout, PB);
    chk("b2b_gap", 128'(cyc - d1), 128'd22);

    @(negedge clk);
    start_op(K1, C1, P1);
    key = rnd128();
    din = rnd128();
    repeat (4) @(negedge clk);
    start = 1'b1;
    key = rnd128();
    din = rnd128();
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("busy_start_out", dout, P1);
    repeat (25) @(negedge clk);

    start_op(KB, CB, PB);
    repeat (14) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    chk("arst_out", dout, 128'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    start_op(K1, C1, P1);
    wait_done();
    chk("after_rst_out", dout, P1);

    for (int n = 0; n < 1000; n++) begin
      k = rnd128();
      p = rnd128();
      if ($urandom_range(1) == 1) @(negedge clk);
      start_op(k, encrypt(k, p), p);
      wait_done();
    end

    repeat (30) @(negedge clk);
    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
